sub_mod_pipe: RTL and testbench
===============================

Name: sub_mod_pipe

Overview:
- Streaming modular subtractor: out = (a - b) mod Q for operands in [0, Q).
- Sits beside the modular adder in the NTT butterfly datapath and feeds the Gentleman-Sande / inverse-NTT difference path.
- Two registered stages with valid/ready flow control, so it can stall under memory-port backpressure without losing or reordering samples.
- Flags operands that violate the [0, Q) precondition.

Parameters:
- W, 24, operand and result width in bits.
- Q, 12587009, modulus. Q < 2^W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operand pair is presented on a, b.
- in_ready  output  1  the block accepts the pair this cycle.
- a  input  W  minuend, expected in [0, Q).
- b  input  W  subtrahend, expected in [0, Q).
- out_valid  output  1  out and out_err hold a valid result.
- out_ready  input  1  the consumer takes the result this cycle.
- out  output  W  (a - b) mod Q.
- out_err  output  1  set when the pair that produced out had a >= Q or b >= Q.
- busy  output  1  at least one pipeline stage holds a sample.

Behaviour:
- Transfers:
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - Producer rule: a, b and in_valid must stay stable while in_valid=1 and in_ready=0.
  - The block holds out and out_err stable while out_valid=1 and out_ready=0.
- Stage 1 (S1): register s1_valid, diff[W:0], err1.
  - diff = {1'b0,a} - {1'b0,b}, computed as W+1-bit two's complement. borrow = diff[W].
  - err1 = (a >= Q) | (b >= Q).
- Stage 2 (S2, drives the outputs): register s2_valid, out, out_err.
  - out = diff[W-1:0] + (borrow ? Q : 0), truncated to W bits.
  - out_err = err1.
- Out-of-range operands: compute with the same formula. The result is deterministic but not guaranteed to be in [0, Q). out_err=1 marks it.
- Advance rules:
  - s2_load = s1_valid & (!s2_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = !s1_valid | !s2_valid | out_ready. This collapses bubbles; the out_ready -> in_ready combinational path is permitted.
  - S1 is overwritten on s1_load. If S1 moves to S2 with no s1_load in the same cycle, s1_valid clears.
  - S2 is overwritten on s2_load. On an output transfer with no s2_load in the same cycle, s2_valid clears.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput 1 pair/cycle with out_ready held high.
- Capacity: 2 samples. With out_ready=0 and both stages full, in_ready=0.
- Simultaneous input transfer, S1->S2 move and output transfer in one cycle: all three occur. No loss, no duplication.
- Ordering: strict FIFO order. Every accepted pair yields exactly one output.
- busy = s1_valid | s2_valid.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out=0, out_err=0, busy=0.
  - in_ready=1 after reset.
  - Data registers diff and err1 also clear to 0.
- Reset mid-operation: all in-flight samples are discarded. out_valid=0 from the cycle after rst is sampled high. No partial result ever appears.
- While rst=1: in_ready is still 1 by the formula, but transfers are ignored.

Test Plan:
- a=5, b=3, single pulse, out_ready=1 -> out_valid exactly 2 cycles later; out=2, out_err=0; busy falls after the output transfer.
- a=3, b=5 (borrow) -> out=12587007. a=0, b=12587008 -> out=1. a=b=12587008 -> out=0. a=12587008, b=0 -> out=12587008.
- Back-to-back stream of 100 random in-range pairs, out_ready=1 -> one result per cycle after a 2-cycle fill; every result matches a reference model, order preserved.
- Backpressure: continuous in_valid, out_ready=0 for 6 cycles ->
  - Exactly 2 pairs accepted, then in_ready=0.
  - out and out_err stay frozen.
  - After out_ready returns, all results arrive in order with none lost or duplicated.
  - Repeat with random out_ready toggling over 500 pairs.
- a=12587009, b=0 -> out_err=1, out=12587009. a=1, b=16777215 -> out_err=1. Next in-range pair has out_err=0.
- Fill both stages with out_ready=0, assert rst for 1 cycle -> out_valid=0 and busy=0 on the next cycle, in_ready=1; the first result after reset matches a freshly sent pair.

Source files
------------

// File: rtl/sub_mod_pipe.sv
// Streaming modular subtractor: out = (a - b) mod Q.
// The block has two registered stages and valid/ready handshakes on both sides.
// A stall at the output fills both stages and then holds off the producer.
// It never drops or reorders a sample.
// out_err marks a result whose operands were outside [0, Q).
module sub_mod_pipe #(
    parameter int          W = 24,
    parameter int unsigned Q = 12587009
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         out_err,
    output logic         busy
);

    localparam logic [W-1:0] QW = W'(Q);

    // Stage 1 state: raw difference with borrow in the MSB, plus the range flag.
    logic         s1_valid;
    logic [W:0]   diff;
    logic         err1;

    // Stage 2 state drives the outputs directly.
    logic         s2_valid;

    logic         s1_load;
    logic         s2_load;
    logic         out_fire;

    // Handshake decode.
    // in_ready depends combinationally on out_ready. A pair can enter whenever
    // a slot frees in the same cycle, so the pipeline never leaves a bubble.
    always_comb begin
        in_ready = !s1_valid || !s2_valid || out_ready;
        s1_load  = in_valid && in_ready;
        s2_load  = s1_valid && (!s2_valid || out_ready);
        out_fire = s2_valid && out_ready;
    end

    // Stage 1: take a new pair, or empty out when its sample moves on to stage 2.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            // NOTE: data registers are cleared too, so the outputs never show
            // stale values after reset. These are plain flops, not a memory.
            diff     <= '0;
            err1     <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            diff     <= {1'b0, a} - {1'b0, b};
            err1     <= (a >= QW) || (b >= QW);
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: fold the borrow back into [0, Q) and hold the result until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out      <= '0;
            out_err  <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            out      <= diff[W-1:0] + (diff[W] ? QW : '0);
            out_err  <= err1;
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    // Status outputs.
    always_comb begin
        out_valid = s2_valid;
        busy      = s1_valid || s2_valid;
    end

endmodule

// File: tb/tb_sub_mod_pipe.sv
// Self-checking bench for sub_mod_pipe.
// A directed vector table covers the modular corner cases.
// Randomized streams with backpressure are compared against a queue-based
// reference model.
module tb_sub_mod_pipe;

    localparam int          W = 24;
    localparam int unsigned Q = 12587009;

    typedef struct {
        logic [W-1:0] o;
        logic         e;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] o;
        logic         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic         out_err;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int out_cnt = 0;
    bit wide_rand = 1'b0;

    res_t         exp_q[$];
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_out;
    logic         prev_err;

    sub_mod_pipe #(.W(W), .Q(Q)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed difference, add Q once if negative, keep W bits.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t   r;
        longint d;
        d = longint'(x) - longint'(y);
        if (d < 0) d = d + longint'(Q);
        r.o = W'(d & ((64'd1 << W) - 1));
        r.e = (x >= W'(Q)) || (y >= W'(Q));
        return r;
    endfunction

    // Scoreboard: in_ready and busy follow the model's occupancy, and results
    // come out in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("busy", busy, exp_q.size() != 0);
            check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_out", out, prev_out);
                check("hold_err", out_err, prev_err);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got out=%0d expected no output", out);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("out", out, r.o);
                    check("out_err", out_err, r.e);
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b));
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
            prev_err   = out_err;
        end
    end

    task automatic new_data();
        if (wide_rand && ($urandom_range(0, 7) == 0)) begin
            a = W'($urandom);
            b = W'($urandom);
        end else begin
            a = W'($urandom_range(0, Q - 1));
            b = W'($urandom_range(0, Q - 1));
        end
    endtask

    // One clock: present out_ready, note whether a pair was accepted.
    // Advance the data only on acceptance, so a stalled pair stays stable.
    task automatic step(input bit rdy, output bit acc);
        out_ready = rdy;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) new_data();
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        check("drain_in_time", k < 20, 1);
        check("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        bit   acc;
        int   lat;
        int   sent;
        int   cycles;
        int   base;
        int   accepted;

        vecs[0] = '{a: 24'd5,        b: 24'd3,        o: 24'd2,        e: 1'b0};
        vecs[1] = '{a: 24'd3,        b: 24'd5,        o: 24'd12587007, e: 1'b0};
        vecs[2] = '{a: 24'd0,        b: 24'd12587008, o: 24'd1,        e: 1'b0};
        vecs[3] = '{a: 24'd12587008, b: 24'd12587008, o: 24'd0,        e: 1'b0};
        vecs[4] = '{a: 24'd12587008, b: 24'd0,        o: 24'd12587008, e: 1'b0};
        vecs[5] = '{a: 24'd12587009, b: 24'd0,        o: 24'd12587009, e: 1'b1};
        vecs[6] = '{a: 24'd1,        b: 24'd16777215, o: 24'd12587011, e: 1'b1};
        vecs[7] = '{a: 24'd100,      b: 24'd40,       o: 24'd60,       e: 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_out_err", out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed vectors, one at a time: latency, value, flag, busy afterwards.
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            in_valid = 1'b1;
            step(1'b1, acc);
            in_valid = 1'b0;
            check("vec_accept", acc, 1);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 10);
            check("vec_latency", lat, 2);
            check("vec_out", out, vecs[i].o);
            check("vec_err", out_err, vecs[i].e);
            @(posedge clk);
            #1;
            check("vec_busy_after", busy, 0);
        end

        // Back-to-back stream of 100 pairs with out_ready held high.
        base = out_cnt;
        new_data();
        in_valid = 1'b1;
        sent = 0;
        cycles = 0;
        while (sent < 100 && cycles < 1000) begin
            step(1'b1, acc);
            sent += int'(acc);
            cycles++;
        end
        in_valid = 1'b0;
        check("stream_cycles", cycles, 100);
        repeat (2) @(negedge clk);
        #1;
        check("stream_outputs", out_cnt - base, 100);
        drain();

        // Backpressure: 6 stalled cycles admit exactly two pairs.
        new_data();
        in_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, acc);
            accepted += int'(acc);
        end
        check("bp_accepted", accepted, 2);
        check("bp_in_ready", in_ready, 0);
        sent = 0;
        cycles = 0;
        while (sent < 4 && cycles < 100) begin
            step(1'b1, acc);
            sent += int'(acc);
            cycles++;
        end
        drain();

        // Random out_ready over 500 pairs, with occasional out-of-range operands.
        wide_rand = 1'b1;
        new_data();
        in_valid = 1'b1;
        sent = 0;
        cycles = 0;
        while (sent < 500 && cycles < 5000) begin
            step(1'($urandom_range(0, 1)), acc);
            sent += int'(acc);
            cycles++;
        end
        check("rand_sent", sent, 500);
        wide_rand = 1'b0;
        drain();

        // Reset with both stages full and the output stalled.
        new_data();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, acc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        a = 24'd7;
        b = 24'd9;
        in_valid = 1'b1;
        step(1'b1, acc);
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check("post_rst_latency", lat, 2);
        check("post_rst_out", out, 24'd12587007);
        check("post_rst_err", out_err, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
